// File: rtl/fall_scheduler.sv
// Falling-character scheduler: steps NSLOT characters down a COLS x ROWS text RAM and resolves typed keys.
// Optional macro SCORE_COUNT_EN enables the saturating hit/miss score counters.
//
// state | meaning
// IDLE  | wait for tick_pending, then key, then spawn
// SCAN  | inspect slot idx; scan ends when idx reaches NSLOT
// ERASE | blank slot idx's cell; free the slot if it sits on the bottom row
// DRAW  | redraw slot idx one row lower
// KCLR  | blank the cell of the slot hit by a key
// SPAWN | draw a new character on row 0
module fall_scheduler #(
    parameter int NSLOT = 2,
    parameter int COLS  = 70,
    parameter int ROWS  = 30
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        spawn_valid,
    output logic        spawn_ready,
    input  logic [7:0]  spawn_ascii,
    input  logic [6:0]  spawn_col,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [7:0]  key_ascii,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        hit_pulse,
    output logic        miss_pulse,
    output logic        wrong_pulse,
    output logic        overrun_pulse,
    output logic [7:0]  hit_count,
    output logic [7:0]  miss_count
);
    localparam int IW = $clog2(NSLOT + 1);
    localparam int SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam logic [12:0] LAST_CELL = 13'(COLS * ROWS - 1);

    typedef enum logic [2:0] {IDLE, SCAN, ERASE, DRAW, KCLR, SPAWN} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic            tick_pending;
    logic [NSLOT-1:0] valid;
    logic [7:0]      ascii [NSLOT];
    logic [11:0]     pos   [NSLOT];

    logic [SW-1:0]   sel;
    logic [11:0]     cur_pos;
    logic [12:0]     next_sum;
    logic            fits;
    logic            consume;
    logic [6:0]      col_clamp;
    logic            any_free;
    logic [SW-1:0]   free_idx;
    logic            key_match;
    logic [SW-1:0]   match_idx;

    assign sel       = idx[SW-1:0];
    assign cur_pos   = pos[sel];
    assign next_sum  = {1'b0, cur_pos} + 13'(COLS);
    assign fits      = next_sum <= LAST_CELL;
    assign consume   = (state == IDLE) && tick_pending;
    assign col_clamp = (int'(spawn_col) >= COLS) ? 7'(COLS - 1) : spawn_col;

    // Descending walk so the lowest matching index is the one left standing.
    always_comb begin
        any_free  = 1'b0;
        free_idx  = '0;
        key_match = 1'b0;
        match_idx = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                any_free = 1'b1;
                free_idx = SW'(i);
            end
            if (valid[i] && ascii[i] == key_ascii) begin
                key_match = 1'b1;
                match_idx = SW'(i);
            end
        end
    end

    assign busy        = (state != IDLE);
    assign key_ready   = (state == IDLE) && !tick_pending;
    assign spawn_ready = key_ready && !key_valid && any_free;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            idx           <= '0;
            tick_pending  <= 1'b0;
            valid         <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                ascii[i] <= '0;
                pos[i]   <= '0;
            end
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            hit_pulse     <= 1'b0;
            miss_pulse    <= 1'b0;
            wrong_pulse   <= 1'b0;
            overrun_pulse <= 1'b0;
        end else begin
            wr_en         <= 1'b0;
            hit_pulse     <= 1'b0;
            miss_pulse    <= 1'b0;
            wrong_pulse   <= 1'b0;
            // A tick landing on the consuming IDLE cycle re-arms rather than overruns.
            tick_pending  <= tick | (tick_pending & ~consume);
            overrun_pulse <= tick & tick_pending & ~consume;
            case (state)
                IDLE: begin
                    if (tick_pending) begin
                        idx   <= '0;
                        state <= SCAN;
                    end else if (key_valid) begin
                        if (key_match) begin
                            valid[match_idx] <= 1'b0;
                            wr_en            <= 1'b1;
                            wr_addr          <= pos[match_idx];
                            wr_data          <= 8'h00;
                            hit_pulse        <= 1'b1;
                            state            <= KCLR;
                        end else begin
                            wrong_pulse <= 1'b1;
                        end
                    end else if (spawn_valid && any_free) begin
                        valid[free_idx] <= 1'b1;
                        ascii[free_idx] <= spawn_ascii;
                        pos[free_idx]   <= {5'd0, col_clamp};
                        wr_en           <= 1'b1;
                        wr_addr         <= {5'd0, col_clamp};
                        wr_data         <= spawn_ascii;
                        state           <= SPAWN;
                    end
                end
                SCAN: begin
                    if (idx == IW'(NSLOT)) begin
                        state <= IDLE;
                    end else if (valid[sel]) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cur_pos;
                        wr_data <= 8'h00;
                        state   <= ERASE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ERASE: begin
                    if (fits) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= next_sum[11:0];
                        wr_data  <= ascii[sel];
                        pos[sel] <= next_sum[11:0];
                        state    <= DRAW;
                    end else begin
                        valid[sel] <= 1'b0;
                        miss_pulse <= 1'b1;
                        idx        <= idx + 1'b1;
                        state      <= SCAN;
                    end
                end
                DRAW: begin
                    idx   <= idx + 1'b1;
                    state <= SCAN;
                end
                KCLR:    state <= IDLE;
                SPAWN:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCORE_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_pulse && hit_count != 8'hFF)
                hit_count <= hit_count + 8'd1;
            if (miss_pulse && miss_count != 8'hFF)
                miss_count <= miss_count + 8'd1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_fall_scheduler.sv
// Bench for fall_scheduler: directed scenarios plus random spawn/key/tick operations
// checked against a slot-list model of the falling characters.
module tb_fall_scheduler;
    localparam int NSLOT = 2;
    localparam int COLS  = 70;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;
    localparam int WINDOW = 10 + 8 * NSLOT;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0;
    logic        spawn_valid = 1'b0;
    logic [7:0]  spawn_ascii = '0;
    logic [6:0]  spawn_col = '0;
    logic        key_valid = 1'b0;
    logic [7:0]  key_ascii = '0;
    logic        spawn_ready, key_ready, wr_en, busy;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        hit_pulse, miss_pulse, wrong_pulse, overrun_pulse;
    logic [7:0]  hit_count, miss_count;

    fall_scheduler #(.NSLOT(NSLOT), .COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
        .spawn_ascii(spawn_ascii), .spawn_col(spawn_col),
        .key_valid(key_valid), .key_ready(key_ready), .key_ascii(key_ascii),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .wrong_pulse(wrong_pulse), .overrun_pulse(overrun_pulse),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a list of falling characters and the writes each operation should cause.
    bit m_valid [NSLOT];
    int m_ascii [NSLOT];
    int m_pos   [NSLOT];
    int m_hits, m_misses, last_addr, last_data;
    int exp_wa[$], exp_wd[$];
    int exp_hit, exp_miss, exp_wrong, exp_ovr, exp_busy;

    int got_wa[$], got_wd[$];
    int n_hit, n_miss, n_wrong, n_ovr, n_busy;

    always @(negedge clk) begin
        if (wr_en) begin
            got_wa.push_back(int'(wr_addr));
            got_wd.push_back(int'(wr_data));
        end
        if (hit_pulse)     n_hit++;
        if (miss_pulse)    n_miss++;
        if (wrong_pulse)   n_wrong++;
        if (overrun_pulse) n_ovr++;
        if (busy)          n_busy++;
    end

    function automatic void model_reset();
        for (int i = 0; i < NSLOT; i++) begin
            m_valid[i] = 1'b0;
            m_ascii[i] = 0;
            m_pos[i]   = 0;
        end
        m_hits = 0; m_misses = 0; last_addr = 0; last_data = 0;
    endfunction

    function automatic int model_any_free();
        for (int i = 0; i < NSLOT; i++)
            if (!m_valid[i]) return 1;
        return 0;
    endfunction

    function automatic void model_spawn(input int a, input int c);
        int col;
        col = (c >= COLS) ? COLS - 1 : c;
        for (int i = 0; i < NSLOT; i++) begin
            if (!m_valid[i]) begin
                m_valid[i] = 1'b1; m_ascii[i] = a; m_pos[i] = col;
                exp_wa.push_back(col); exp_wd.push_back(a);
                exp_busy += 1;
                return;
            end
        end
    endfunction

    function automatic void model_key(input int a);
        for (int i = 0; i < NSLOT; i++) begin
            if (m_valid[i] && m_ascii[i] == a) begin
                m_valid[i] = 1'b0;
                exp_wa.push_back(m_pos[i]); exp_wd.push_back(0);
                exp_hit++; m_hits++; exp_busy += 1;
                return;
            end
        end
        exp_wrong++;
    endfunction

    // A scan costs one closing cycle, 1 per empty slot, 3 per falling slot, 2 per slot leaving the screen.
    function automatic void model_tick();
        exp_busy += 1;
        for (int i = 0; i < NSLOT; i++) begin
            if (!m_valid[i]) begin
                exp_busy += 1;
            end else begin
                exp_wa.push_back(m_pos[i]); exp_wd.push_back(0);
                if (m_pos[i] + COLS <= CELLS - 1) begin
                    m_pos[i] += COLS;
                    exp_wa.push_back(m_pos[i]); exp_wd.push_back(m_ascii[i]);
                    exp_busy += 3;
                end else begin
                    m_valid[i] = 1'b0;
                    exp_miss++; m_misses++;
                    exp_busy += 2;
                end
            end
        end
    endfunction

    task automatic begin_op();
        @(posedge clk); #1;
        got_wa.delete(); got_wd.delete(); exp_wa.delete(); exp_wd.delete();
        n_hit = 0; n_miss = 0; n_wrong = 0; n_ovr = 0; n_busy = 0;
        exp_hit = 0; exp_miss = 0; exp_wrong = 0; exp_ovr = 0; exp_busy = 0;
    endtask

    task automatic end_op(input string nm);
        int hc, mc;
        repeat (WINDOW) @(posedge clk);
        @(negedge clk); #1;
        chk({nm, "_idle"}, busy, 0);
        chk({nm, "_nwr"}, got_wa.size(), exp_wa.size());
        for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
            chk({nm, "_waddr"}, got_wa[i], exp_wa[i]);
            chk({nm, "_wdata"}, got_wd[i], exp_wd[i]);
        end
        if (exp_wa.size() > 0) begin
            last_addr = exp_wa[exp_wa.size() - 1];
            last_data = exp_wd[exp_wd.size() - 1];
        end
        chk({nm, "_hold_addr"}, wr_addr, last_addr);
        chk({nm, "_hold_data"}, wr_data, last_data);
        chk({nm, "_hit"}, n_hit, exp_hit);
        chk({nm, "_miss"}, n_miss, exp_miss);
        chk({nm, "_wrong"}, n_wrong, exp_wrong);
        chk({nm, "_ovr"}, n_ovr, exp_ovr);
        chk({nm, "_busy_cyc"}, n_busy, exp_busy);
`ifdef SCORE_COUNT_EN
        hc = (m_hits > 255) ? 255 : m_hits;
        mc = (m_misses > 255) ? 255 : m_misses;
`else
        hc = 0;
        mc = 0;
`endif
        chk({nm, "_hit_count"}, hit_count, hc);
        chk({nm, "_miss_count"}, miss_count, mc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {hit_pulse, miss_pulse, wrong_pulse, overrun_pulse}, 0);
        chk("rst_counts", {hit_count, miss_count}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        #1;
        chk("rst_spawn_ready", spawn_ready, 1);
        chk("rst_key_ready", key_ready, 1);
    endtask

    task automatic op_spawn(input logic [7:0] a, input logic [6:0] c);
        begin_op();
        spawn_ascii = a; spawn_col = c; spawn_valid = 1'b1;
        @(negedge clk);
        chk("spawn_ready", spawn_ready, model_any_free());
        @(posedge clk); #1;
        spawn_valid = 1'b0;
        model_spawn(int'(a), int'(c));
        end_op("spawn");
    endtask

    task automatic op_key(input logic [7:0] a, input bit with_spawn);
        begin_op();
        key_ascii = a; key_valid = 1'b1;
        spawn_valid = with_spawn; spawn_ascii = 8'h55; spawn_col = 7'd3;
        @(negedge clk);
        chk("key_ready", key_ready, 1);
        chk("spawn_blocked_by_key", spawn_ready, 0);
        @(posedge clk); #1;
        key_valid = 1'b0; spawn_valid = 1'b0;
        model_key(int'(a));
        end_op("key");
    endtask

    task automatic op_tick();
        begin_op();
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        chk("tick_key_ready", key_ready, 0);
        chk("tick_spawn_ready", spawn_ready, 0);
        model_tick();
        end_op("tick");
    endtask

    // Tick, then two back-to-back ticks while the first scan is still running.
    task automatic op_overrun();
        begin_op();
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        @(posedge clk); #1;
        tick = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        tick = 1'b0;
        model_tick();
        model_tick();
        exp_ovr = 1;
        end_op("ovr");
    endtask

    task automatic reset_in_draw();
        bit found;
        begin_op();
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (wr_en && wr_data != 8'h00) found = 1'b1;
        end
        chk("rdraw_seen", found, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rdraw_wr_en", wr_en, 0);
        chk("rdraw_busy", busy, 0);
        got_wa.delete(); got_wd.delete();
        repeat (3) @(negedge clk);
        chk("rdraw_no_writes", got_wa.size(), 0);
        reset_n = 1'b1;
        model_reset();
        #1;
        chk("rdraw_spawn_ready", spawn_ready, 1);
        chk("rdraw_key_ready", key_ready, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        model_reset();
        do_reset();

        op_spawn(8'h41, 7'd20);
        op_tick();

        do_reset();
        op_spawn(8'h41, 7'd20);
        op_spawn(8'h42, 7'd40);
        op_tick();

        do_reset();
        op_spawn(8'h41, 7'd20);
        for (int t = 0; t < ROWS - 1; t++) op_tick();
        chk("bottom_pos", m_pos[0], 2050);
        op_tick();

        do_reset();
        op_spawn(8'h43, 7'd5);
        op_spawn(8'h43, 7'd9);
        op_key(8'h43, 1'b0);
        op_key(8'h5A, 1'b1);
        op_key(8'h43, 1'b0);

        op_spawn(8'h58, 7'd99);
        op_overrun();
        reset_in_draw();

        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40)
                op_tick();
            else if (r < 75)
                op_spawn(8'(8'h41 + $urandom_range(0, 3)), 7'($urandom_range(0, 99)));
            else if (r < 95)
                op_key(8'(8'h41 + $urandom_range(0, 4)), 1'($urandom_range(0, 1)));
            else
                op_overrun();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
